// File: rtl/counter_pkg.sv
// Shared mode encodings and saturation-bound helper for the up/down counter core.
package counter_pkg;

    localparam logic [1:0] MODE_ALL  = 2'b00;
    localparam logic [1:0] MODE_EVEN = 2'b01;
    localparam logic [1:0] MODE_ODD  = 2'b10;
    localparam logic [1:0] MODE_STEP = 2'b11;

    // LSB of the mode max (upper=1) or min (upper=0); the remaining bits are
    // all ones for the max and all zeros for the min.
    function automatic logic limit_lsb(input logic [1:0] mode, input logic upper);
        if (upper) begin
            return (mode != MODE_EVEN);
        end
        return (mode == MODE_ODD);
    endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// Clock-enable prescaler: one tick every 2^(PRE_SHIFT*freq_sel) enabled cycles,
// restarted by a clear strobe or by any change of freq_sel.
module cnt_prescaler #(
    parameter int PRE_SHIFT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [2:0] freq_sel,
    input  logic       clear,
    output logic       tick
);

    localparam int PRE_W = 7 * PRE_SHIFT;

    logic [PRE_W-1:0] cnt_q, cnt_d;
    logic [2:0]       fs_q, fs_d;
    logic [PRE_W:0]   one_hot;
    logic [PRE_W-1:0] limit;
    logic             changed;

    // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
    always_comb begin
        fs_d    = freq_sel;
        changed = (freq_sel != fs_q);
        one_hot = (PRE_W+1)'(1) << (PRE_SHIFT * int'(fs_q));
        limit   = PRE_W'(one_hot - (PRE_W+1)'(1));
        tick    = en && !clear && !changed && (cnt_q == limit);
        cnt_d   = cnt_q;
        if (clear || changed) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == limit) ? '0 : cnt_q + PRE_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            fs_q  <= freq_sel;
        end else begin
            cnt_q <= cnt_d;
            fs_q  <= fs_d;
        end
    end

endmodule

// File: rtl/counter_ud_mode_presc.sv
// N-bit up/down counter with all/even/odd/step modes, prescaled enable, load, tc and invert.
// Define CNT_SAT_EN to clamp at the mode limits instead of wrapping modulo 2^N.
module counter_ud_mode_presc
    import counter_pkg::*;
#(
    parameter int N         = 8,
    parameter int PRE_SHIFT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         ud,
    input  logic [1:0]   mode,
    input  logic [N-1:0] step_val,
    input  logic [2:0]   freq_sel,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         inv,
    output logic [N-1:0] q,
    output logic         tc,
    output logic         tick
);

    logic [N-1:0] cnt_q, cnt_d;
    logic         tc_q, tc_d;
    logic         tick_q, tick_d;
    logic         presc_tick;
    logic [N-1:0] delta;
    logic [N:0]   sum;
    logic         wrap;
    logic [N-1:0] stepped;

    cnt_prescaler #(.PRE_SHIFT(PRE_SHIFT)) u_presc (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .freq_sel (freq_sel),
        .clear    (load),
        .tick     (presc_tick)
    );

    always_comb begin
        case (mode)
            MODE_ALL:  delta = N'(1);
            MODE_EVEN: delta = cnt_q[0] ? N'(1) : N'(2);
            MODE_ODD:  delta = cnt_q[0] ? N'(2) : N'(1);
            default:   delta = step_val;
        endcase

        // The extra MSB carries out (up) or borrows (down) exactly when the step leaves 0..2^N-1.
        sum  = ud ? ({1'b0, cnt_q} + {1'b0, delta}) : ({1'b0, cnt_q} - {1'b0, delta});
        wrap = sum[N];

`ifdef CNT_SAT_EN
        if (wrap) begin
            stepped = ud ? {{(N-1){1'b1}}, limit_lsb(mode, 1'b1)}
                         : {{(N-1){1'b0}}, limit_lsb(mode, 1'b0)};
        end else begin
            stepped = sum[N-1:0];
        end
`else
        stepped = sum[N-1:0];
`endif

        cnt_d  = cnt_q;
        tc_d   = 1'b0;
        tick_d = 1'b0;
        if (load) begin
            cnt_d = load_val;
        end else if (presc_tick) begin
            cnt_d  = stepped;
            tc_d   = wrap;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            tc_q   <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tc_q   <= tc_d;
            tick_q <= tick_d;
        end
    end

    assign q    = inv ? ~cnt_q : cnt_q;
    assign tc   = tc_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_counter_ud_mode_presc.sv
// Self-checking bench for counter_ud_mode_presc: directed scenarios plus randomized traffic
// against an integer reference model.
module tb_counter_ud_mode_presc;

    localparam int N         = 8;
    localparam int PRE_SHIFT = 1;
    localparam int MAXV      = (1 << N) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         ud;
    logic [1:0]   mode;
    logic [N-1:0] step_val;
    logic [2:0]   freq_sel;
    logic         load;
    logic [N-1:0] load_val;
    logic         inv;
    logic [N-1:0] q;
    logic         tc;
    logic         tick;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state, plain integers.
    int m_cnt, m_pre, m_fs, m_tc, m_tick;

    always #5 clk = ~clk;

    counter_ud_mode_presc #(.N(N), .PRE_SHIFT(PRE_SHIFT)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .ud       (ud),
        .mode     (mode),
        .step_val (step_val),
        .freq_sel (freq_sel),
        .load     (load),
        .load_val (load_val),
        .inv      (inv),
        .q        (q),
        .tc       (tc),
        .tick     (tick)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        int  period, d, nxt;
        bit  changed, is_tick;
        if (reset) begin
            m_cnt = 0; m_pre = 0; m_fs = int'(freq_sel); m_tc = 0; m_tick = 0;
            return;
        end
        period  = 1 << (PRE_SHIFT * m_fs);
        changed = (int'(freq_sel) != m_fs);
        m_fs    = int'(freq_sel);
        is_tick = en && !changed && !load && (m_pre == period - 1);
        if (load || changed) m_pre = 0;
        else if (en)         m_pre = (m_pre + 1) % period;
        m_tc = 0; m_tick = 0;
        if (load) begin
            m_cnt = int'(load_val);
        end else if (is_tick) begin
            case (mode)
                2'd0:    d = 1;
                2'd1:    d = (m_cnt % 2 == 0) ? 2 : 1;
                2'd2:    d = (m_cnt % 2 == 1) ? 2 : 1;
                default: d = int'(step_val);
            endcase
            nxt    = ud ? m_cnt + d : m_cnt - d;
            m_tick = 1;
            if (nxt > MAXV || nxt < 0) begin
                m_tc = 1;
`ifdef CNT_SAT_EN
                begin
                    int lo, hi;
                    hi  = (mode == 2'd1) ? MAXV - 1 : MAXV;
                    lo  = (mode == 2'd2) ? 1 : 0;
                    nxt = (nxt < 0) ? lo : hi;
                end
`else
                nxt = ((nxt % (MAXV + 1)) + MAXV + 1) % (MAXV + 1);
`endif
            end
            m_cnt = nxt;
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, "_mq"},    32'(q),    32'(inv ? (~m_cnt & MAXV) : m_cnt));
        check({tag, "_mtc"},   32'(tc),   32'(m_tc));
        check({tag, "_mtick"}, 32'(tick), 32'(m_tick));
    endtask

    task automatic step_expect(input string tag, input logic [7:0] exp_q, input logic exp_tc);
        cycle(tag);
        check({tag, "_q"},  32'(q),  32'(exp_q));
        check({tag, "_tc"}, 32'(tc), 32'(exp_tc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] corners [4];
        corners = '{8'h00, 8'h01, 8'hFE, 8'hFF};

        reset = 1'b1; en = 1'b0; ud = 1'b1; mode = 2'd0; step_val = '0;
        freq_sel = 3'd0; load = 1'b0; load_val = '0; inv = 1'b0;

        // Reset state
        cycle("rst0");
        cycle("rst1");
        check("rst_q", 32'(q), 32'h00);
        check("rst_tick", 32'(tick), 32'h0);
        inv = 1'b1; #1;
        check("rst_inv_q", 32'(q), 32'hFF);
        inv = 1'b0;

`ifndef CNT_SAT_EN
        // Mode all, up, wrap through zero
        reset = 1'b0; en = 1'b1; load = 1'b1; load_val = 8'hFE;
        step_expect("t1_ld", 8'hFE, 1'b0);
        load = 1'b0;
        step_expect("t1_a", 8'hFF, 1'b0);
        step_expect("t1_b", 8'h00, 1'b1);
        step_expect("t1_c", 8'h01, 1'b0);

        // Even mode realign, then down with wrap
        mode = 2'd1; load = 1'b1; load_val = 8'h03;
        step_expect("t2_ld", 8'h03, 1'b0);
        load = 1'b0;
        step_expect("t2_a", 8'h04, 1'b0);
        step_expect("t2_b", 8'h06, 1'b0);
        step_expect("t2_c", 8'h08, 1'b0);
        ud = 1'b0;
        step_expect("t2_d", 8'h06, 1'b0);
        step_expect("t2_e", 8'h04, 1'b0);
        step_expect("t2_f", 8'h02, 1'b0);
        step_expect("t2_g", 8'h00, 1'b0);
        step_expect("t2_h", 8'hFE, 1'b1);

        // Odd mode down, then step of zero holds
        mode = 2'd2; load = 1'b1; load_val = 8'h04;
        step_expect("t3_ld", 8'h04, 1'b0);
        load = 1'b0;
        step_expect("t3_a", 8'h03, 1'b0);
        step_expect("t3_b", 8'h01, 1'b0);
        step_expect("t3_c", 8'hFF, 1'b1);
        mode = 2'd3; step_val = 8'h00;
        step_expect("t3_d", 8'hFF, 1'b0);
        step_expect("t3_e", 8'hFF, 1'b0);
`else
        reset = 1'b0; en = 1'b1;
`endif

        // Prescaler rate and mid-period rate change
        mode = 2'd0; ud = 1'b1; load = 1'b1; load_val = 8'h00;
        step_expect("t4_ld", 8'h00, 1'b0);
        load = 1'b0; freq_sel = 3'd3;
        cycle("t4_chg");
        check("t4_chg_tick", 32'(tick), 32'h0);
        for (int i = 1; i <= 24; i++) begin
            cycle("t4_run");
            check("t4_tick8", 32'(tick), 32'((i % 8) == 0));
        end
        check("t4_q3", 32'(q), 32'h03);
        for (int i = 0; i < 3; i++) cycle("t4_mid");
        freq_sel = 3'd1;
        cycle("t4_chg2");
        check("t4_chg2_tick", 32'(tick), 32'h0);
        for (int i = 1; i <= 4; i++) begin
            cycle("t4_run2");
            check("t4_tick2", 32'(tick), 32'((i % 2) == 0));
        end

        // Reset beats load; enable freeze; load on a tick cycle
        reset = 1'b1; load = 1'b1; load_val = 8'h55; freq_sel = 3'd2;
        step_expect("t5_rstld", 8'h00, 1'b0);
        reset = 1'b0; load = 1'b0;
        cycle("t5_pre1");
        cycle("t5_pre2");
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle("t5_frz");
            check("t5_frz_q", 32'(q), 32'h00);
            check("t5_frz_tick", 32'(tick), 32'h0);
        end
        en = 1'b1;
        cycle("t5_pre3");
        check("t5_pre3_tick", 32'(tick), 32'h0);
        load = 1'b1; load_val = 8'h3C;
        step_expect("t5_ldtick", 8'h3C, 1'b0);
        check("t5_ldtick_tick", 32'(tick), 32'h0);
        load = 1'b0;
        cycle("t5_after");
        check("t5_after_q", 32'(q), 32'h3C);
        inv = 1'b1; #1;
        check("t5_inv_q", 32'(q), 32'hC3);
        inv = 1'b0;

`ifdef CNT_SAT_EN
        // Saturating even mode at the top
        freq_sel = 3'd0; mode = 2'd1; ud = 1'b1; load = 1'b1; load_val = 8'hFC;
        step_expect("t6_ld", 8'hFC, 1'b0);
        load = 1'b0;
        step_expect("t6_a", 8'hFE, 1'b0);
        step_expect("t6_b", 8'hFE, 1'b1);
        step_expect("t6_c", 8'hFE, 1'b1);
        inv = 1'b1; #1;
        check("t6_inv_q", 32'(q), 32'h01);
        inv = 1'b0;
        mode = 2'd2; ud = 1'b0; load = 1'b1; load_val = 8'h02;
        step_expect("t6_ld2", 8'h02, 1'b0);
        load = 1'b0;
        step_expect("t6_d", 8'h01, 1'b0);
        step_expect("t6_e", 8'h01, 1'b1);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(0, 63) == 0);
            load     = ($urandom_range(0, 15) == 0);
            en       = ($urandom_range(0, 3) != 0);
            ud       = 1'($urandom_range(0, 1));
            mode     = 2'($urandom_range(0, 3));
            step_val = N'($urandom);
            load_val = ($urandom_range(0, 1) == 1) ? N'($urandom) : corners[$urandom_range(0, 3)];
            inv      = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 31) == 0) freq_sel = 3'($urandom_range(0, 2));
            cycle("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
